// File: rtl/match_sequencer_pkg.sv
// Shared definitions for the match sequencer: phase encodings, winner codes and
// small score helpers used by the FSM and the prescaler.
package match_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_KICKOFF    = 3'd1,
    PH_PLAY       = 3'd2,
    PH_GOAL_PAUSE = 3'd3,
    PH_OVER       = 3'd4
  } phase_e;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_BLUE = 2'b01;
  localparam logic [1:0] WINNER_RED  = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  localparam int DEFAULT_MATCH_SECONDS = 180;

  // Score array indices, also the bit positions in the goal vector
  localparam int TEAM_BLUE = 0;
  localparam int TEAM_RED  = 1;

  function automatic logic [6:0] sat_inc(input logic [6:0] score, input logic [6:0] limit);
    return (score >= limit) ? score : score + 7'd1;
  endfunction

  function automatic logic [1:0] decide_winner(input logic [6:0] blue, input logic [6:0] red);
    if (blue > red)
      return WINNER_BLUE;
    else if (red > blue)
      return WINNER_RED;
    return WINNER_DRAW;
  endfunction

  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/match_sequencer_tick.sv
// One-second tick generator: counts 0..CLK_FREQ_HZ-1 and flags the terminal count.
// The synchronous clear restarts the second so a fresh phase gets a full period.
module sec_tick_gen
  import match_sequencer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = count_width(CLK_FREQ_HZ);
  localparam logic [CW-1:0] TERM = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] count_reg;

  assign tick = (count_reg == TERM);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count_reg <= '0;
    else if (tick)
      count_reg <= '0;
    else
      count_reg <= count_reg + 1'b1;
  end

endmodule

// File: rtl/match_sequencer.sv
// Match-level sequencer: game phase FSM, match clock, kickoff/pause countdown and
// both score registers. All outputs come straight from registers.
module match_sequencer
  import match_sequencer_pkg::*;
#(
  parameter int CLK_FREQ_HZ        = 50_000_000,
  parameter int MATCH_SECONDS      = DEFAULT_MATCH_SECONDS,
  parameter int KICKOFF_SECONDS    = 3,
  parameter int GOAL_PAUSE_SECONDS = 2,
  parameter int SCORE_MAX          = 99,
  parameter int WIN_SCORE          = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_req,
  input  logic       blue_goal,
  input  logic       red_goal,
  output logic       play_en,
  output logic       pos_reset,
  output logic [2:0] phase,
  output logic [3:0] countdown,
  output logic [7:0] time_left,
  output logic [6:0] blue_score,
  output logic [6:0] red_score,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [7:0] MATCH_INIT   = 8'(MATCH_SECONDS);
  localparam logic [3:0] KICKOFF_INIT = 4'(KICKOFF_SECONDS);
  localparam logic [3:0] PAUSE_INIT   = 4'(GOAL_PAUSE_SECONDS);
  localparam logic [6:0] SCORE_LIMIT  = 7'(SCORE_MAX);

  phase_e     state_reg, state_next;
  logic       start_q_reg;
  logic       start_rise;
  logic       tick;
  logic       phase_change;
  logic       goal;
  logic       final_tick;
  logic       win_reached;
  logic [1:0] goal_vec;

  logic [3:0] countdown_reg, countdown_next;
  logic [7:0] time_left_reg, time_left_next;
  logic [6:0] score_reg  [2];
  logic [6:0] score_next [2];
  logic [6:0] score_inc  [2];

  logic       play_en_reg;
  logic       pos_reset_reg;
  logic       game_over_reg;
  logic [1:0] winner_reg;

  assign start_rise = start_req & ~start_q_reg;
  assign goal_vec   = {red_goal, blue_goal};
  assign goal       = |goal_vec;
  assign final_tick = tick && (time_left_reg == 8'd1);

  // Candidate post-goal score per team; only committed while in PLAY
  for (genvar gi = 0; gi < 2; gi++) begin : g_team
    assign score_inc[gi] = goal_vec[gi] ? sat_inc(score_reg[gi], SCORE_LIMIT) : score_reg[gi];
  end

  if (WIN_SCORE != 0) begin : g_win
    localparam logic [6:0] WIN_LIMIT = 7'(WIN_SCORE);
    assign win_reached = goal &&
                         ((score_inc[TEAM_BLUE] >= WIN_LIMIT) || (score_inc[TEAM_RED] >= WIN_LIMIT));
  end else begin : g_no_win
    assign win_reached = 1'b0;
  end

  sec_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_sec_tick (
    .clk (clk),
    .rst (rst),
    .clr (phase_change),
    .tick(tick)
  );

  always_comb begin
    state_next     = state_reg;
    countdown_next = countdown_reg;
    time_left_next = time_left_reg;
    score_next[0]  = score_reg[0];
    score_next[1]  = score_reg[1];

    unique case (state_reg)
      PH_IDLE: begin
        if (start_rise) begin
          state_next     = PH_KICKOFF;
          time_left_next = MATCH_INIT;
          score_next[0]  = '0;
          score_next[1]  = '0;
        end
      end
      PH_KICKOFF: begin
        if (tick) begin
          if (countdown_reg == 4'd1)
            state_next = PH_PLAY;
          else
            countdown_next = countdown_reg - 4'd1;
        end
      end
      PH_PLAY: begin
        score_next[0] = score_inc[0];
        score_next[1] = score_inc[1];
        if (tick)
          time_left_next = time_left_reg - 8'd1;
        // Match end wins over a goal pause; a goal on the final tick still scores
        if (final_tick || win_reached)
          state_next = PH_OVER;
        else if (goal)
          state_next = PH_GOAL_PAUSE;
      end
      PH_GOAL_PAUSE: begin
        if (tick) begin
          if (countdown_reg == 4'd1)
            state_next = PH_KICKOFF;
          else
            countdown_next = countdown_reg - 4'd1;
        end
      end
      PH_OVER: begin
        if (start_rise)
          state_next = PH_IDLE;
      end
      default: state_next = PH_IDLE;
    endcase

    if (state_next != state_reg) begin
      unique case (state_next)
        PH_KICKOFF:    countdown_next = KICKOFF_INIT;
        PH_GOAL_PAUSE: countdown_next = PAUSE_INIT;
        default:       countdown_next = '0;
      endcase
    end
  end

  assign phase_change = (state_next != state_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= PH_IDLE;
      start_q_reg   <= 1'b0;
      countdown_reg <= '0;
      time_left_reg <= MATCH_INIT;
      for (int i = 0; i < 2; i++)
        score_reg[i] <= '0;
    end else begin
      state_reg     <= state_next;
      start_q_reg   <= start_req;
      countdown_reg <= countdown_next;
      time_left_reg <= time_left_next;
      for (int i = 0; i < 2; i++)
        score_reg[i] <= score_next[i];
    end
  end

  // Decoded outputs are registered from the next state so they line up with phase
  always_ff @(posedge clk) begin
    if (rst) begin
      play_en_reg   <= 1'b0;
      pos_reset_reg <= 1'b0;
      game_over_reg <= 1'b0;
      winner_reg    <= WINNER_NONE;
    end else begin
      play_en_reg   <= (state_next == PH_PLAY);
      pos_reset_reg <= phase_change && (state_next == PH_KICKOFF);
      game_over_reg <= (state_next == PH_OVER);
      winner_reg    <= (state_next == PH_OVER) ?
                       decide_winner(score_next[TEAM_BLUE], score_next[TEAM_RED]) : WINNER_NONE;
    end
  end

  assign play_en    = play_en_reg;
  assign pos_reset  = pos_reset_reg;
  assign phase      = state_reg;
  assign countdown  = countdown_reg;
  assign time_left  = time_left_reg;
  assign blue_score = score_reg[TEAM_BLUE];
  assign red_score  = score_reg[TEAM_RED];
  assign game_over  = game_over_reg;
  assign winner     = winner_reg;

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: two instances (no early win / WIN_SCORE=2) each tracked by a
// cycle-level game model, plus directed scenarios with hand-computed expectations.
module tb_match_sequencer;

  localparam int CLKF  = 4;
  localparam int MATCH = 5;
  localparam int KS    = 2;
  localparam int GS    = 1;

  logic clk;
  logic rst_a, st_a, bg_a, rg_a;
  logic rst_b, st_b, bg_b, rg_b;

  logic       play_en_a, pos_reset_a, game_over_a;
  logic [2:0] phase_a;
  logic [3:0] countdown_a;
  logic [7:0] time_left_a;
  logic [6:0] blue_a, red_a;
  logic [1:0] winner_a;

  logic       play_en_b, pos_reset_b, game_over_b;
  logic [2:0] phase_b;
  logic [3:0] countdown_b;
  logic [7:0] time_left_b;
  logic [6:0] blue_b, red_b;
  logic [1:0] winner_b;

  int checks = 0;
  int errors = 0;

  match_sequencer #(
    .CLK_FREQ_HZ(CLKF), .MATCH_SECONDS(MATCH), .KICKOFF_SECONDS(KS),
    .GOAL_PAUSE_SECONDS(GS), .SCORE_MAX(3), .WIN_SCORE(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start_req(st_a), .blue_goal(bg_a), .red_goal(rg_a),
    .play_en(play_en_a), .pos_reset(pos_reset_a), .phase(phase_a), .countdown(countdown_a),
    .time_left(time_left_a), .blue_score(blue_a), .red_score(red_a),
    .game_over(game_over_a), .winner(winner_a)
  );

  match_sequencer #(
    .CLK_FREQ_HZ(CLKF), .MATCH_SECONDS(MATCH), .KICKOFF_SECONDS(KS),
    .GOAL_PAUSE_SECONDS(GS), .SCORE_MAX(99), .WIN_SCORE(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start_req(st_b), .blue_goal(bg_b), .red_goal(rg_b),
    .play_en(play_en_b), .pos_reset(pos_reset_b), .phase(phase_b), .countdown(countdown_b),
    .time_left(time_left_b), .blue_score(blue_b), .red_score(red_b),
    .game_over(game_over_b), .winner(winner_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural game model ----------------
  typedef struct {
    bit valid;
    int phase;
    int cd;
    int tl;
    int bs;
    int rs;
    int elapsed;     // cycles since the current second started
    bit start_prev;
    bit posr;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, bit r, bit s, bit bg, bit rg, int smax, int win);
    mdl_t n;
    bit rise;
    bit tick;
    int np;
    n = m;
    if (r) begin
      n.valid = 1; n.phase = 0; n.cd = 0; n.tl = MATCH; n.bs = 0; n.rs = 0;
      n.elapsed = 0; n.start_prev = 0; n.posr = 0;
      return n;
    end
    rise = s && !m.start_prev;
    n.start_prev = s;
    tick = (m.elapsed == CLKF - 1);
    np = m.phase;
    case (m.phase)
      0: if (rise) begin np = 1; n.bs = 0; n.rs = 0; n.tl = MATCH; end
      1, 3: if (tick) begin
        if (m.cd == 1) np = (m.phase == 1) ? 2 : 1;
        else n.cd = m.cd - 1;
      end
      2: begin
        if (bg) n.bs = (m.bs + 1 > smax) ? smax : m.bs + 1;
        if (rg) n.rs = (m.rs + 1 > smax) ? smax : m.rs + 1;
        if (tick) n.tl = m.tl - 1;
        if (tick && n.tl == 0) np = 4;
        else if ((bg || rg) && win != 0 && (n.bs >= win || n.rs >= win)) np = 4;
        else if (bg || rg) np = 3;
      end
      4: if (rise) np = 0;
      default: ;
    endcase
    n.posr = (np == 1 && m.phase != 1);
    if (np != m.phase) begin
      n.elapsed = 0;
      n.cd = (np == 1) ? KS : (np == 3) ? GS : 0;
    end else begin
      n.elapsed = tick ? 0 : m.elapsed + 1;
    end
    n.phase = np;
    return n;
  endfunction

  function automatic logic [33:0] mexp(mdl_t m);
    logic [1:0] w;
    w = 2'b00;
    if (m.phase == 4) w = (m.bs > m.rs) ? 2'b01 : (m.rs > m.bs) ? 2'b10 : 2'b11;
    return {m.phase == 2, m.posr, 3'(m.phase), 4'(m.cd), 8'(m.tl), 7'(m.bs), 7'(m.rs),
            m.phase == 4, w};
  endfunction

  always @(posedge clk) begin
    ma = mstep(ma, rst_a, st_a, bg_a, rg_a, 3, 0);
    mb = mstep(mb, rst_b, st_b, bg_b, rg_b, 99, 2);
  end

  logic [33:0] got_a, got_b;
  assign got_a = {play_en_a, pos_reset_a, phase_a, countdown_a, time_left_a, blue_a, red_a,
                  game_over_a, winner_a};
  assign got_b = {play_en_b, pos_reset_b, phase_b, countdown_b, time_left_b, blue_b, red_b,
                  game_over_b, winner_b};

  always @(negedge clk) begin
    if (ma.valid) begin
      checks++;
      if (got_a !== mexp(ma)) begin
        errors++;
        $display("FAIL cycle_a t=%0t got %h want %h", $time, got_a, mexp(ma));
      end
    end
    if (mb.valid) begin
      checks++;
      if (got_b !== mexp(mb)) begin
        errors++;
        $display("FAIL cycle_b t=%0t got %h want %h", $time, got_b, mexp(mb));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic wait_phase(input bit b, input int ph, input int maxc, output int n);
    n = 0;
    while (int'(b ? phase_b : phase_a) != ph) begin
      if (n >= maxc) begin
        checks++; errors++;
        $display("FAIL wait_phase dut%0d timeout got %0d want %0d", b, int'(b ? phase_b : phase_a), ph);
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_tl(input bit b, input int tl, input int maxc);
    int n;
    n = 0;
    while (int'(b ? time_left_b : time_left_a) != tl) begin
      if (n >= maxc) begin
        checks++; errors++;
        $display("FAIL wait_tl dut%0d timeout got %0d want %0d", b, int'(b ? time_left_b : time_left_a), tl);
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse(input bit b, input bit blue, input bit red);
    if (b) begin bg_b = blue; rg_b = red; end
    else begin bg_a = blue; rg_a = red; end
    @(negedge clk);
    bg_a = 0; rg_a = 0; bg_b = 0; rg_b = 0;
  endtask

  task automatic press(input bit b);
    if (b) st_b = 1; else st_a = 1;
    @(negedge clk);
    st_a = 0; st_b = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int posr_cycles;
    int kick_at;
    int play_at;
    rst_a = 1; st_a = 0; bg_a = 0; rg_a = 0;
    rst_b = 1; st_b = 0; bg_b = 0; rg_b = 0;
    repeat (2) @(negedge clk);
    rst_a = 0; rst_b = 0;

    // 1: reset state, held start, full match to a 0-0 draw
    check("rst_phase", int'(phase_a), 0);
    check("rst_time", int'(time_left_a), 5);
    check("rst_winner", int'(winner_a), 0);
    posr_cycles = 0; kick_at = -1; play_at = -1;
    st_a = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pos_reset_a) posr_cycles++;
      if (phase_a == 3'd1 && kick_at < 0) kick_at = i;
      if (phase_a == 3'd2 && play_at < 0) play_at = i;
    end
    st_a = 0;
    check("t1_pos_reset_cycles", posr_cycles, 1);
    check("t1_kickoff_at", kick_at, 0);
    check("t1_play_at", play_at, 8);
    wait_phase(0, 4, 40, n);
    check("t1_play_to_over_rest", n, 9);
    check("t1_time_left", int'(time_left_a), 0);
    check("t1_winner", int'(winner_a), 3);
    check("t1_game_over", int'(game_over_a), 1);

    // 2: blue goal at time_left=3
    press(0);
    check("t2_idle", int'(phase_a), 0);
    press(0);
    check("t2_kickoff", int'(phase_a), 1);
    wait_phase(0, 2, 20, n);
    wait_tl(0, 3, 20);
    pulse(0, 1, 0);
    check("t2_phase_pause", int'(phase_a), 3);
    check("t2_blue", int'(blue_a), 1);
    check("t2_countdown", int'(countdown_a), 1);
    wait_phase(0, 1, 20, n);
    check("t2_pause_len", n, 4);
    check("t2_pos_reset", int'(pos_reset_a), 1);
    wait_phase(0, 2, 20, n);
    check("t2_kickoff_len", n, 8);
    check("t2_time_frozen", int'(time_left_a), 3);

    // 3: simultaneous goals
    pulse(0, 1, 1);
    check("t3_blue", int'(blue_a), 2);
    check("t3_red", int'(red_a), 1);
    @(negedge clk);
    check("t3_single_pause", int'(phase_a), 3);

    // 5: ignored goals, saturation at SCORE_MAX=3
    pulse(0, 0, 1);
    check("t5_red_in_pause", int'(red_a), 1);
    wait_phase(0, 1, 20, n);
    pulse(0, 1, 0);
    check("t5_blue_in_kickoff", int'(blue_a), 2);
    wait_phase(0, 2, 20, n);
    pulse(0, 1, 0);
    check("t5_blue_to_max", int'(blue_a), 3);
    wait_phase(0, 1, 20, n);
    wait_phase(0, 2, 20, n);
    pulse(0, 1, 0);
    check("t5_blue_saturated", int'(blue_a), 3);
    check("t5_sat_goal_pause", int'(phase_a), 3);
    wait_phase(0, 1, 20, n);
    wait_phase(0, 2, 20, n);
    wait_phase(0, 4, 40, n);
    check("t5_winner_blue", int'(winner_a), 1);
    pulse(0, 0, 1);
    check("t5_red_in_over", int'(red_a), 1);

    // 6b: OVER -> IDLE keeps scores; next start clears them
    press(0);
    check("t6_idle_blue_kept", int'(blue_a), 3);
    press(0);
    check("t6_blue_cleared", int'(blue_a), 0);
    check("t6_time_reload", int'(time_left_a), 5);

    // 4: red goal on the final tick
    wait_phase(0, 2, 20, n);
    wait_tl(0, 1, 30);
    repeat (3) @(negedge clk);
    pulse(0, 0, 1);
    check("t4_phase_over", int'(phase_a), 4);
    check("t4_red", int'(red_a), 1);
    check("t4_time", int'(time_left_a), 0);
    check("t4_winner_red", int'(winner_a), 2);

    // 6a: reset mid-PLAY
    press(0);
    press(0);
    wait_phase(0, 2, 20, n);
    pulse(0, 1, 0);
    wait_phase(0, 1, 20, n);
    wait_phase(0, 2, 20, n);
    wait_tl(0, 2, 30);
    check("t6_pre_blue", int'(blue_a), 1);
    rst_a = 1;
    @(negedge clk);
    rst_a = 0;
    check("t6_rst_phase", int'(phase_a), 0);
    check("t6_rst_time", int'(time_left_a), 5);
    check("t6_rst_blue", int'(blue_a), 0);
    check("t6_rst_play_en", int'(play_en_a), 0);
    check("t6_rst_countdown", int'(countdown_a), 0);

    // 5: early win with WIN_SCORE=2
    press(1);
    wait_phase(1, 2, 20, n);
    pulse(1, 1, 0);
    check("tw_first_goal_pause", int'(phase_b), 3);
    wait_phase(1, 1, 20, n);
    wait_phase(1, 2, 20, n);
    pulse(1, 1, 0);
    check("tw_phase_over", int'(phase_b), 4);
    check("tw_blue", int'(blue_b), 2);
    check("tw_winner", int'(winner_b), 1);
    check("tw_game_over", int'(game_over_b), 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
